debounce_synchronizer: RTL and testbench

DEBOUNCE_SYNCHRONIZER -- requirements
Module: debounce_synchronizer

---
 rtl/debounce_synchronizer.sv | 146 ++++++++++++++
 tb/tb_debounce_synchronizer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/debounce_synchronizer.sv
// rtl/debounce_synchronizer.sv - two-flop synchronizer followed by a debounce qualification FSM
//
// Purpose:
//   Brings an asynchronous, bouncing level (switch or pin) into the clk
//   domain and only accepts a level change once the synchronized value has
//   been stable for STABLE_CYCLES consecutive qualification cycles.
//   Candidate changes that collapse before qualifying are counted as glitches.
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronized cycles needed to accept a change (2..65535)
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high reset
//   noisy_in      asynchronous bouncing input level
//   level_out     registered debounced level
//   busy          registered; high while a candidate change is being qualified
//   glitch_count  saturating count of rejected candidate changes

module debounce_synchronizer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noisy_in,
  output logic       level_out,
  output logic       busy,
  output logic [7:0] glitch_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_LOW      = 2'd0;
  localparam logic [1:0] ST_CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_CHK_LOW  = 2'd3;

  logic             sync1_q;
  logic             sync2_q;
  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             level_q,  level_d;
  logic             busy_q,   busy_d;
  logic             abort;

  // Only sync1_q ever samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= noisy_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    abort    = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = ST_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_CHK_LOW;
          cnt_d   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase

    // Saturate rather than wrap; an abort at 255 leaves the count at 255.
    if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end

    // Outputs are computed from the next state so they are flops aligned
    // with the state register, not decoded combinationally after it.
    busy_d = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);

    if (state_d == ST_HIGH) begin
      level_d = 1'b1;
    end else if (state_d == ST_LOW) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      glitch_q <= 8'd0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
    end
  end

  assign level_out    = level_q;
  assign busy         = busy_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_debounce_synchronizer.sv
// tb/tb_debounce_synchronizer.sv - directed self-checking bench for debounce_synchronizer

module tb_debounce_synchronizer;

  logic       clk;
  logic       reset;
  logic       noisy_in;
  logic       level_out;
  logic       busy;
  logic [7:0] glitch_count;

  logic       noisy2;
  logic       level2;
  logic       busy2;
  logic [7:0] glitch2;

  int total;
  int bad;

  debounce_synchronizer #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .noisy_in     (noisy_in),
    .level_out    (level_out),
    .busy         (busy),
    .glitch_count (glitch_count)
  );

  debounce_synchronizer #(.STABLE_CYCLES(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .noisy_in     (noisy2),
    .level_out    (level2),
    .busy         (busy2),
    .glitch_count (glitch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    noisy_in = 1'b0;
    noisy2   = 1'b0;
    tick();
    tick();
    check("reset_level", {31'd0, level_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_glitch", {24'd0, glitch_count}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_level", {31'd0, level_out}, 32'd0);

    // Clean rise: busy for edges 3..6, level on edge 7.
    noisy_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rise_busy_e%0d", e), {31'd0, busy}, ((e >= 3) && (e <= 6)) ? 32'd1 : 32'd0);
      check($sformatf("rise_level_e%0d", e), {31'd0, level_out}, (e == 7) ? 32'd1 : 32'd0);
    end
    check("rise_glitch", {24'd0, glitch_count}, 32'd0);

    // Clean fall from HIGH.
    noisy_in = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("fall_busy_e%0d", e), {31'd0, busy}, ((e >= 3) && (e <= 6)) ? 32'd1 : 32'd0);
      check($sformatf("fall_level_e%0d", e), {31'd0, level_out}, (e == 7) ? 32'd0 : 32'd1);
    end
    check("fall_glitch", {24'd0, glitch_count}, 32'd0);
    tick();

    // Bounce on rise: high 2, low 1, then held high.
    noisy_in = 1'b1;
    tick();
    tick();
    noisy_in = 1'b0;
    tick();
    noisy_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("bounce_level_e%0d", e), {31'd0, level_out}, (e == 7) ? 32'd1 : 32'd0);
    end
    check("bounce_glitch", {24'd0, glitch_count}, 32'd1);

    noisy_in = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    check("bounce_fall_level", {31'd0, level_out}, 32'd0);
    check("bounce_fall_glitch", {24'd0, glitch_count}, 32'd1);

    // Reset while in CHK_HIGH with counter=2.
    noisy_in = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_level", {31'd0, level_out}, 32'd0);
    check("midreset_glitch", {24'd0, glitch_count}, 32'd0);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("postreset_busy_e%0d", e), {31'd0, busy}, ((e >= 3) && (e <= 6)) ? 32'd1 : 32'd0);
      check($sformatf("postreset_level_e%0d", e), {31'd0, level_out}, (e == 7) ? 32'd1 : 32'd0);
    end
    noisy_in = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    check("postreset_fall_level", {31'd0, level_out}, 32'd0);

    // Saturation: 300 rejected 2-cycle glitches, 5 edges each.
    for (int g = 1; g <= 300; g++) begin
      noisy_in = 1'b1;
      tick();
      tick();
      noisy_in = 1'b0;
      tick();
      tick();
      tick();
      if ((g == 1) || (g == 254) || (g == 255) || (g == 256) || (g == 300)) begin
        check($sformatf("sat_glitch_g%0d", g), {24'd0, glitch_count}, (g < 255) ? g : 32'd255);
        check($sformatf("sat_level_g%0d", g), {31'd0, level_out}, 32'd0);
      end
    end

    // STABLE_CYCLES=2: a 1-cycle sync2 high is rejected.
    noisy2 = 1'b1;
    tick();
    noisy2 = 1'b0;
    for (int e = 2; e <= 7; e++) begin
      tick();
      check($sformatf("b2_short_level_e%0d", e), {31'd0, level2}, 32'd0);
    end
    check("b2_short_glitch", {24'd0, glitch2}, 32'd1);

    // A held change is accepted on the fifth edge.
    noisy2 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("b2_held_level_e%0d", e), {31'd0, level2}, (e == 5) ? 32'd1 : 32'd0);
    end
    check("b2_held_glitch", {24'd0, glitch2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
